// File: rtl/datapath_pkg.sv
// Shared datapath types for the fetch path: instruction words and the
// record handed from the fetch unit to the scoreboard.
package datapath_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic  valid;
        word_t instr;
        word_t pc;
    } fetch_t;

    localparam word_t INSTR_BYTES = 32'd4;

    function automatic word_t next_pc(input word_t pc);
        return pc + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue between instruction memory and the scoreboard. The head entry
// is presented straight from storage, so it changes only on a clock edge.
module fetch_fifo
    import datapath_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  fetch_t                 push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output fetch_t                 head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_t             mem_q [DEPTH];
    fetch_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push_s;
    logic               do_pop_s;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == CNT_W'(0));
    assign count = count_q;

    // Head view: the valid bit reflects occupancy, not stale storage.
    always_comb begin
        head       = mem_q[rd_ptr_q];
        head.valid = !empty;
    end

    // Next-state for storage, pointers and occupancy; a push into a full
    // queue is accepted only when the head leaves in the same cycle.
    always_comb begin
        mem_d     = mem_q;
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_data;
            end else begin
                mem_d = mem_q;
            end
            wr_ptr_d = do_push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
            rd_ptr_d = do_pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
            count_d  = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    // Queue state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word requests, queues responses for the
// scoreboard and handles redirects, draining any in-flight request first.
module fetch_unit
    import datapath_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000,
    parameter int    FQ_DEPTH = 2
) (
    input  logic   CLK,
    input  logic   nRST,
    output logic   imem_ren,
    output word_t  imem_addr,
    input  logic   imem_ihit,
    input  word_t  imem_instr,
    input  logic   freeze,
    input  logic   flush,
    input  word_t  flush_pc,
    output fetch_t fetch
);

    localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    word_t              pc_q, pc_d;
    word_t              redir_q, redir_d;
    logic               ren_q, ren_d;

    logic               push_s;
    logic               pop_s;
    logic [CNT_W-1:0]   count_next_s;
    logic               fq_full;
    logic               fq_empty;
    logic [CNT_W-1:0]   fq_count;
    fetch_t             push_entry_s;

    assign push_entry_s = '{valid: 1'b1, instr: imem_instr, pc: pc_q};
    assign imem_ren     = ren_q;
    assign imem_addr    = pc_q;

    // Next-state logic. imem_ren is registered so an issued request cannot be
    // withdrawn by a same-cycle flush; the request is drained instead.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_d      = redir_q;
        ren_d        = ren_q;
        push_s       = 1'b0;
        pop_s        = !fq_empty && !freeze && !flush;
        count_next_s = fq_count;
        case (state_q)
            FETCH: begin
                if (flush) begin
                    ren_d = 1'b1;
                    if (ren_q && !imem_ihit) begin
                        redir_d = flush_pc;
                        state_d = DRAIN;
                    end else begin
                        pc_d = flush_pc;
                    end
                end else begin
                    push_s       = ren_q && imem_ihit && (!fq_full || pop_s);
                    pc_d         = push_s ? next_pc(pc_q) : pc_q;
                    count_next_s = fq_count + CNT_W'(push_s) - CNT_W'(pop_s);
                    ren_d        = (count_next_s != CNT_W'(FQ_DEPTH));
                end
            end
            DRAIN: begin
                if (imem_ihit) begin
                    pc_d    = flush ? flush_pc : redir_q;
                    ren_d   = 1'b0;
                    state_d = REDIRECT;
                end else begin
                    redir_d = flush ? flush_pc : redir_q;
                    ren_d   = 1'b1;
                end
            end
            REDIRECT: begin
                pc_d    = flush ? flush_pc : pc_q;
                ren_d   = 1'b1;
                state_d = FETCH;
            end
            default: begin
                state_d = FETCH;
                ren_d   = 1'b0;
            end
        endcase
    end

    // FSM, fetch address, redirect target and request strobe.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            redir_q <= 32'h0000_0000;
            ren_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            redir_q <= redir_d;
            ren_q   <= ren_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (nRST),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .flush     (flush),
        .full      (fq_full),
        .empty     (fq_empty),
        .count     (fq_count),
        .head      (fetch)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, corner-case sequences, then
// randomized traffic checked against a queue-based behavioural model.
module tb_fetch_unit;
    import datapath_pkg::*;

    localparam int DEPTH = 2;

    logic   CLK = 1'b0;
    logic   nRST;
    logic   imem_ren;
    word_t  imem_addr;
    logic   imem_ihit;
    word_t  imem_instr;
    logic   freeze;
    logic   flush;
    word_t  flush_pc;
    fetch_t fetch;

    always #5 CLK = ~CLK;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .FQ_DEPTH (DEPTH)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imem_ren   (imem_ren),
        .imem_addr  (imem_addr),
        .imem_ihit  (imem_ihit),
        .imem_instr (imem_instr),
        .freeze     (freeze),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .fetch      (fetch)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        rst_n;
        logic        ihit;
        logic        frz;
        logic        fl;
        logic [31:0] fpc;
        logic        exp_ren;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    vec_t vecs [20];

    // Reference model state
    ent_t        mq [$];
    logic [31:0] m_pc;
    logic [31:0] m_tgt;
    bit          m_ren;
    bit          m_drain;
    bit          m_gap;

    // Random-phase stimulus
    logic        r_rst_n, r_ihit, r_frz, r_fl;
    logic [31:0] r_fpc, r_ins;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic vec_t mkv(input logic r, input logic ih, input logic fz, input logic fl,
                                 input logic [31:0] fp, input logic er, input logic [31:0] ea,
                                 input logic ev, input logic [31:0] ep);
        vec_t v;
        v.rst_n = r; v.ihit = ih; v.frz = fz; v.fl = fl; v.fpc = fp;
        v.exp_ren = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ih, input logic fz, input logic fl,
                         input logic [31:0] fp, input logic [31:0] ins);
        nRST = r; imem_ihit = ih; freeze = fz; flush = fl; flush_pc = fp; imem_instr = ins;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One cycle with memory returning the word at the address being requested.
    task automatic cyc(input logic r, input logic ih, input logic fz, input logic fl,
                       input logic [31:0] fp);
        drive(r, ih, fz, fl, fp, mem_word(imem_addr));
        tick();
    endtask

    task automatic expect_out(input string tag, input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep);
        chk({tag, ".ren"}, {31'd0, imem_ren}, {31'd0, er});
        chk({tag, ".addr"}, imem_addr, ea);
        chk({tag, ".valid"}, {31'd0, fetch.valid}, {31'd0, ev});
        if (ev) begin
            chk({tag, ".pc"}, fetch.pc, ep);
            chk({tag, ".instr"}, fetch.instr, mem_word(ep));
        end
    endtask

    task automatic expect_reset_fetch(input string tag);
        chk({tag, ".rst_valid"}, {31'd0, fetch.valid}, 32'd0);
        chk({tag, ".rst_pc"}, fetch.pc, 32'd0);
        chk({tag, ".rst_instr"}, fetch.instr, 32'd0);
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc = 32'd0; m_tgt = 32'd0;
        m_ren = 1'b0; m_drain = 1'b0; m_gap = 1'b0;
    endtask

    // Behaviour over one clock edge, written as request/queue bookkeeping.
    task automatic model_step(input logic r, input logic ih, input logic fz, input logic fl,
                              input logic [31:0] fp, input logic [31:0] ins);
        bit hit;
        hit = m_ren && ih;
        if (!r) begin
            model_reset();
        end else if (m_drain) begin
            if (hit) begin
                m_pc = fl ? fp : m_tgt;
                m_drain = 1'b0; m_gap = 1'b1; m_ren = 1'b0;
            end else if (fl) begin
                m_tgt = fp;
            end
        end else if (m_gap) begin
            if (fl) m_pc = fp;
            m_gap = 1'b0; m_ren = 1'b1;
        end else if (fl) begin
            mq.delete();
            if (m_ren && !ih) begin
                m_drain = 1'b1; m_tgt = fp;
            end else begin
                m_pc = fp;
            end
            m_ren = 1'b1;
        end else begin
            if (mq.size() != 0 && !fz) mq.delete(0);
            if (hit) begin
                mq.push_back('{instr: ins, pc: m_pc});
                m_pc = m_pc + 32'd4;
            end
            m_ren = (mq.size() < DEPTH);
        end
    endtask

    initial begin
        // Directed table: reset, streaming, freeze back-pressure, flush during a pending request.
        vecs[0]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0);
        vecs[1]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0);
        vecs[2]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0);
        vecs[3]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4);
        vecs[4]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b0, 32'h0);
        vecs[5]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0);
        vecs[6]  = mkv(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0);
        vecs[7]  = mkv(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0);
        vecs[8]  = mkv(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h8,   1'b1, 32'h0);
        vecs[9]  = mkv(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h8,   1'b1, 32'h0);
        vecs[10] = mkv(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h8,   1'b1, 32'h0);
        vecs[11] = mkv(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h8,   1'b1, 32'h0);
        vecs[12] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4);
        vecs[13] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b0, 32'h0);
        vecs[14] = mkv(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 32'h8,   1'b0, 32'h0);
        vecs[15] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b0, 32'h0);
        vecs[16] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b0, 32'h0);
        vecs[17] = mkv(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h100, 1'b0, 32'h0);
        vecs[18] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0);
        vecs[19] = mkv(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        nRST = 1'b0;
        tick();

        for (int i = 0; i < 20; i++) begin
            cyc(vecs[i].rst_n, vecs[i].ihit, vecs[i].frz, vecs[i].fl, vecs[i].fpc);
            expect_out($sformatf("vec%0d", i), vecs[i].exp_ren, vecs[i].exp_addr,
                       vecs[i].exp_valid, vecs[i].exp_pc);
            if (!vecs[i].rst_n) expect_reset_fetch($sformatf("vec%0d", i));
        end

        // Flush coinciding with ihit (and freeze): response dropped, queue emptied.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("fhit.pre", 1'b1, 32'h4, 1'b1, 32'h0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
        expect_out("fhit.flush", 1'b1, 32'h200, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("fhit.resume", 1'b1, 32'h204, 1'b1, 32'h200);

        // Flush with freeze while the queue is full and no request is out.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        expect_out("ffrz.full", 1'b0, 32'h8, 1'b1, 32'h0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h340);
        expect_out("ffrz.flush", 1'b1, 32'h340, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("ffrz.resume", 1'b1, 32'h344, 1'b1, 32'h340);

        // Reset asserted while draining an outstanding request.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h500);
        expect_out("rdrn.drain", 1'b1, 32'h4, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        nRST = 1'b0;
        #1;
        expect_out("rdrn.async", 1'b0, 32'h0, 1'b0, 32'h0);
        expect_reset_fetch("rdrn.async");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("rdrn.hold", 1'b0, 32'h0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("rdrn.rel", 1'b1, 32'h0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("rdrn.first", 1'b1, 32'h4, 1'b1, 32'h0);

        // Randomized traffic against the reference model.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        model_reset();
        for (int i = 0; i < 4000; i++) begin
            r_rst_n = ($urandom_range(0, 299) != 0);
            r_ihit  = 1'($urandom_range(0, 1));
            r_frz   = ($urandom_range(0, 9) < 3);
            r_fl    = ($urandom_range(0, 19) == 0);
            r_fpc   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
            r_ins   = $urandom;
            drive(r_rst_n, r_ihit, r_frz, r_fl, r_fpc, r_ins);
            model_step(r_rst_n, r_ihit, r_frz, r_fl, r_fpc, r_ins);
            tick();
            chk($sformatf("rnd%0d.ren", i), {31'd0, imem_ren}, {31'd0, m_ren});
            chk($sformatf("rnd%0d.addr", i), imem_addr, m_pc);
            chk($sformatf("rnd%0d.valid", i), {31'd0, fetch.valid}, {31'd0, mq.size() != 0});
            if (mq.size() != 0) begin
                chk($sformatf("rnd%0d.pc", i), fetch.pc, mq[0].pc);
                chk($sformatf("rnd%0d.instr", i), fetch.instr, mq[0].instr);
            end else if (!r_rst_n) begin
                expect_reset_fetch($sformatf("rnd%0d", i));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
